dcache_miss_ctrl: RTL and testbench

Miss controller for the write-back, write-allocate, set-associative data cache. It accepts one miss request at a time (single MSHR), picks a victim way and writes it back to memory if it is dirty. It then refills the line, merges store data and updates the tag/data/state arrays. Bypass (uncached) requests go straight to memory without touching the arrays.

---
 rtl/dcache_miss_ctrl_if.sv | 57 +++++
 rtl/dcache_miss_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_miss_ctrl_if.sv
// rtl/dcache_miss_ctrl_if.sv - miss request, tag/data/state array and memory signals of the miss controller
interface dcache_miss_ctrl_if #(
  parameter int SET_ASSOCIATIVITY = 8,
  parameter int INDEX_WIDTH       = 7,
  parameter int TAG_WIDTH         = 27,
  parameter int CACHE_LINE_WIDTH  = 64,
  parameter int PADDR_WIDTH       = 34
);
  logic                         miss_valid_i;
  logic                         miss_ready_o;
  logic [PADDR_WIDTH-1:0]       miss_addr_i;
  logic                         miss_we_i;
  logic [31:0]                  miss_wdata_i;
  logic [3:0]                   miss_be_i;
  logic                         miss_bypass_i;
  logic                         mshr_valid_o;
  logic [PADDR_WIDTH-1:0]       mshr_addr_o;
  logic                         done_o;
  logic [CACHE_LINE_WIDTH-1:0]  rdata_o;
  logic                         arr_req_o;
  logic                         arr_we_o;
  logic [INDEX_WIDTH-4:0]       arr_idx_o;
  logic [SET_ASSOCIATIVITY-1:0] arr_way_o;
  logic [TAG_WIDTH-1:0]         arr_wtag_o;
  logic [CACHE_LINE_WIDTH-1:0]  arr_wdata_o;
  logic                         arr_wdirty_o;
  logic [SET_ASSOCIATIVITY-1:0] arr_valid_i;
  logic [SET_ASSOCIATIVITY-1:0] arr_dirty_i;
  logic [TAG_WIDTH-1:0]         arr_rtag_i;
  logic [CACHE_LINE_WIDTH-1:0]  arr_rdata_i;
  logic                         mem_req_o;
  logic                         mem_gnt_i;
  logic                         mem_we_o;
  logic [PADDR_WIDTH-1:0]       mem_addr_o;
  logic [CACHE_LINE_WIDTH-1:0]  mem_wdata_o;
  logic [7:0]                   mem_be_o;
  logic                         mem_rvalid_i;
  logic [CACHE_LINE_WIDTH-1:0]  mem_rdata_i;

  modport master (
    output miss_valid_i, miss_addr_i, miss_we_i, miss_wdata_i, miss_be_i, miss_bypass_i,
    output arr_valid_i, arr_dirty_i, arr_rtag_i, arr_rdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  miss_ready_o, mshr_valid_o, mshr_addr_o, done_o, rdata_o,
    input  arr_req_o, arr_we_o, arr_idx_o, arr_way_o, arr_wtag_o, arr_wdata_o, arr_wdirty_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport slave (
    input  miss_valid_i, miss_addr_i, miss_we_i, miss_wdata_i, miss_be_i, miss_bypass_i,
    input  arr_valid_i, arr_dirty_i, arr_rtag_i, arr_rdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output miss_ready_o, mshr_valid_o, mshr_addr_o, done_o, rdata_o,
    output arr_req_o, arr_we_o, arr_idx_o, arr_way_o, arr_wtag_o, arr_wdata_o, arr_wdirty_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// rtl/dcache_miss_ctrl.sv - single-MSHR write-back/write-allocate data cache miss controller
module dcache_miss_ctrl #(
  parameter int SET_ASSOCIATIVITY = 8,
  parameter int INDEX_WIDTH       = 7,
  parameter int TAG_WIDTH         = 27,
  parameter int CACHE_LINE_WIDTH  = 64,
  parameter int PADDR_WIDTH       = 34
) (
  input logic              clk_i,
  input logic              rst_i,
  dcache_miss_ctrl_if.slave bus
);
  localparam int WAY_BITS = $clog2(SET_ASSOCIATIVITY);
  localparam int IDX_BITS = INDEX_WIDTH - 3;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_STATE, S_RD_WAIT, S_RD_VICT, S_VICT_WAIT, S_WB_REQ,
    S_RF_REQ, S_RF_WAIT, S_UPDATE, S_BYP_REQ, S_BYP_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [WAY_BITS-1:0]          rr;
  logic [WAY_BITS-1:0]          victim;
  logic [WAY_BITS-1:0]          victim_sel;
  logic                         all_valid;
  logic                         victim_dirty;
  logic [PADDR_WIDTH-1:0]       req_addr;
  logic                         req_we;
  logic [31:0]                  req_wdata;
  logic [3:0]                   req_be;
  logic [TAG_WIDTH-1:0]         victim_tag;
  logic [CACHE_LINE_WIDTH-1:0]  line_buf;
  logic [CACHE_LINE_WIDTH-1:0]  merged;
  logic [IDX_BITS-1:0]          req_idx;
  logic [TAG_WIDTH-1:0]         req_tag;
  logic [SET_ASSOCIATIVITY-1:0] victim_oh;

  assign req_idx   = req_addr[INDEX_WIDTH-1:3];
  assign req_tag   = req_addr[PADDR_WIDTH-1:INDEX_WIDTH];
  assign victim_oh = SET_ASSOCIATIVITY'(1) << victim;

  // Lowest-index invalid way wins; round-robin only when the whole set is valid.
  always_comb begin
    victim_sel = rr;
    all_valid  = 1'b1;
    for (int w = SET_ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (!bus.arr_valid_i[w]) begin
        victim_sel = WAY_BITS'(w);
        all_valid  = 1'b0;
      end
    end
    victim_dirty = bus.arr_valid_i[victim_sel] && bus.arr_dirty_i[victim_sel];
  end

  always_comb begin
    merged = line_buf;
    if (req_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) merged[{req_addr[2], 2'(b), 3'b000} +: 8] = req_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (bus.miss_valid_i) state_nxt = bus.miss_bypass_i ? S_BYP_REQ : S_RD_STATE;
      S_RD_STATE:  state_nxt = S_RD_WAIT;
      S_RD_WAIT:   state_nxt = victim_dirty ? S_RD_VICT : S_RF_REQ;
      S_RD_VICT:   state_nxt = S_VICT_WAIT;
      S_VICT_WAIT: state_nxt = S_WB_REQ;
      S_WB_REQ:    if (bus.mem_gnt_i) state_nxt = S_RF_REQ;
      S_RF_REQ:    if (bus.mem_gnt_i) state_nxt = S_RF_WAIT;
      S_RF_WAIT:   if (bus.mem_rvalid_i) state_nxt = S_UPDATE;
      S_UPDATE:    state_nxt = S_IDLE;
      S_BYP_REQ:   if (bus.mem_gnt_i) state_nxt = req_we ? S_IDLE : S_BYP_WAIT;
      S_BYP_WAIT:  if (bus.mem_rvalid_i) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.miss_ready_o = (state == S_IDLE) && !rst_i;
    bus.mshr_valid_o = (state != S_IDLE);
    bus.mshr_addr_o  = (state != S_IDLE) ? req_addr : '0;
    bus.done_o       = 1'b0;
    bus.rdata_o      = '0;
    bus.arr_req_o    = 1'b0;
    bus.arr_we_o     = 1'b0;
    bus.arr_idx_o    = '0;
    bus.arr_way_o    = '0;
    bus.arr_wtag_o   = '0;
    bus.arr_wdata_o  = '0;
    bus.arr_wdirty_o = 1'b0;
    bus.mem_req_o    = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_wdata_o  = '0;
    bus.mem_be_o     = '0;
    case (state)
      S_RD_STATE: begin
        bus.arr_req_o = 1'b1;
        bus.arr_idx_o = req_idx;
        bus.arr_way_o = '1;
      end
      S_RD_VICT: begin
        bus.arr_req_o = 1'b1;
        bus.arr_idx_o = req_idx;
        bus.arr_way_o = victim_oh;
      end
      S_WB_REQ: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = {victim_tag, req_idx, 3'b000};
        bus.mem_wdata_o = line_buf;
        bus.mem_be_o    = 8'hFF;
      end
      S_RF_REQ: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = {req_tag, req_idx, 3'b000};
        bus.mem_be_o   = 8'hFF;
      end
      S_UPDATE: begin
        bus.arr_req_o    = 1'b1;
        bus.arr_we_o     = 1'b1;
        bus.arr_idx_o    = req_idx;
        bus.arr_way_o    = victim_oh;
        bus.arr_wtag_o   = req_tag;
        bus.arr_wdata_o  = merged;
        bus.arr_wdirty_o = req_we;
        bus.done_o       = 1'b1;
        bus.rdata_o      = merged;
      end
      S_BYP_REQ: begin
        // Uncached loads fetch the whole addressed word; stores use their own byte enables.
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = req_we;
        bus.mem_addr_o  = req_addr;
        bus.mem_wdata_o = {2{req_wdata}};
        if (req_we) bus.mem_be_o = req_addr[2] ? {req_be, 4'h0} : {4'h0, req_be};
        else        bus.mem_be_o = req_addr[2] ? 8'hF0 : 8'h0F;
        bus.done_o      = req_we && bus.mem_gnt_i;
      end
      S_BYP_WAIT: begin
        bus.done_o  = bus.mem_rvalid_i;
        bus.rdata_o = bus.mem_rvalid_i ? bus.mem_rdata_i : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr         <= '0;
      victim     <= '0;
      req_addr   <= '0;
      req_we     <= 1'b0;
      req_wdata  <= '0;
      req_be     <= '0;
      victim_tag <= '0;
      line_buf   <= '0;
    end else begin
      if (state == S_IDLE && bus.miss_valid_i) begin
        req_addr  <= bus.miss_addr_i;
        req_we    <= bus.miss_we_i;
        req_wdata <= bus.miss_wdata_i;
        req_be    <= bus.miss_be_i;
      end
      if (state == S_RD_WAIT) begin
        victim <= victim_sel;
        if (all_valid) rr <= rr + 1'b1;
      end
      if (state == S_VICT_WAIT) begin
        victim_tag <= bus.arr_rtag_i;
        line_buf   <= bus.arr_rdata_i;
      end
      if (state == S_RF_WAIT && bus.mem_rvalid_i) line_buf <= bus.mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb/tb_dcache_miss_ctrl.sv - transaction-level scoreboard bench for the data cache miss controller
module tb_dcache_miss_ctrl;
  typedef struct packed {
    logic        we;
    logic [3:0]  idx;
    logic [7:0]  way;
    logic [26:0] tag;
    logic [63:0] data;
    logic        dirty;
  } arr_op_t;
  typedef struct packed {
    logic        we;
    logic [33:0] addr;
    logic [7:0]  be;
    logic [63:0] data;
  } mem_op_t;
  typedef struct packed {
    logic        chk;
    logic [63:0] data;
  } done_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_miss_ctrl_if bus ();
  dcache_miss_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0, errors = 0;
  arr_op_t arr_q[$];
  mem_op_t mem_q[$];
  done_t   done_q[$];
  int rr_model = 0;

  logic [7:0]  arr_valid_v = 8'h00, arr_dirty_v = 8'h00;
  logic [26:0] vict_tag_v = '0;
  logic [63:0] vict_data_v = '0, refill_line = '0;
  int gnt_delay = 0, rv_delay = 0;

  logic        busy = 1'b0;
  logic [33:0] busy_addr = '0;
  int done_cnt = 0, arr_cnt = 0, mem_wr_cnt = 0, req_run = 0, last_req_run = 0;
  logic [7:0]  last_way = '0, last_mem_be = '0;
  logic [63:0] last_wdata = '0, last_mem_wdata = '0, last_done = '0;
  logic        last_wdirty = 1'b0;
  logic [33:0] last_rd_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the ordered array/memory operations and result a miss must produce.
  task automatic expect_txn(input logic [33:0] a, input logic we, input logic [31:0] wd,
                            input logic [3:0] be, input logic byp);
    arr_op_t ao;
    mem_op_t mo;
    done_t   dn;
    logic [63:0] line;
    int vic, ofs;
    mo = '0;
    ao = '0;
    if (byp) begin
      mo.we = we; mo.addr = a; mo.data = {wd, wd};
      if (we) mo.be = a[2] ? {be, 4'h0} : {4'h0, be};
      else    mo.be = a[2] ? 8'hF0 : 8'h0F;
      mem_q.push_back(mo);
      dn.chk = !we; dn.data = refill_line;
      done_q.push_back(dn);
      return;
    end
    vic = -1;
    for (int w = 0; w < 8; w++) if (!arr_valid_v[w] && vic < 0) vic = w;
    if (vic < 0) begin
      vic = rr_model;
      rr_model = (rr_model + 1) % 8;
    end
    ao.idx = a[6:3]; ao.way = 8'hFF;
    arr_q.push_back(ao);
    if (arr_valid_v[vic] && arr_dirty_v[vic]) begin
      ao.way = 8'(1 << vic);
      arr_q.push_back(ao);
      mo.we = 1'b1; mo.addr = {vict_tag_v, a[6:3], 3'b000}; mo.be = 8'hFF; mo.data = vict_data_v;
      mem_q.push_back(mo);
    end
    mo.we = 1'b0; mo.addr = {a[33:7], a[6:3], 3'b000}; mo.be = 8'hFF; mo.data = '0;
    mem_q.push_back(mo);
    line = refill_line;
    if (we) for (int b = 0; b < 4; b++) begin
      ofs = (a[2] ? 32 : 0) + 8 * b;
      if (be[b]) line[ofs +: 8] = wd[b*8 +: 8];
    end
    ao.we = 1'b1; ao.way = 8'(1 << vic); ao.tag = a[33:7]; ao.data = line; ao.dirty = we;
    arr_q.push_back(ao);
    dn.chk = 1'b1; dn.data = line;
    done_q.push_back(dn);
  endtask

  // Environment: array answers one cycle after a read, memory grants after gnt_delay.
  initial begin : responder
    logic p_state_rd, p_way_rd, in_req;
    int gcnt, rv_cnt;
    p_state_rd = 0; p_way_rd = 0; in_req = 0; gcnt = 0; rv_cnt = 0;
    bus.arr_valid_i = '0; bus.arr_dirty_i = '0; bus.arr_rtag_i = '0; bus.arr_rdata_i = '0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      bus.arr_valid_i  = p_state_rd ? arr_valid_v : ~arr_valid_v;
      bus.arr_dirty_i  = p_state_rd ? arr_dirty_v : ~arr_dirty_v;
      bus.arr_rtag_i   = p_way_rd ? vict_tag_v : ~vict_tag_v;
      bus.arr_rdata_i  = p_way_rd ? vict_data_v : ~vict_data_v;
      bus.mem_rvalid_i = (rv_cnt == 1);
      if (rv_cnt > 0) rv_cnt--;
      bus.mem_rdata_i  = bus.mem_rvalid_i ? refill_line : ~refill_line;
      bus.mem_gnt_i    = 1'b0;
      if (bus.mem_req_o) begin
        if (!in_req) begin in_req = 1; gcnt = gnt_delay; end
        if (gcnt > 0) gcnt--;
        else begin
          bus.mem_gnt_i = 1'b1;
          in_req = 0;
          if (!bus.mem_we_o) rv_cnt = rv_delay + 1;
        end
      end else in_req = 0;
      p_state_rd = bus.arr_req_o && !bus.arr_we_o && (bus.arr_way_o == 8'hFF);
      p_way_rd   = bus.arr_req_o && !bus.arr_we_o && (bus.arr_way_o != 8'hFF);
    end
  end

  initial begin : compare
    arr_op_t ea;
    mem_op_t em, held;
    done_t   ed;
    logic    hold;
    hold = 0; held = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ready_in_reset", bus.miss_ready_o, 0);
        arr_q.delete(); mem_q.delete(); done_q.delete();
        busy = 0; hold = 0; req_run = 0;
      end else begin
        chk("miss_ready", bus.miss_ready_o, !busy);
        chk("mshr_valid", bus.mshr_valid_o, busy);
        if (busy) chk("mshr_addr", bus.mshr_addr_o, busy_addr);
        if (bus.arr_req_o) begin
          arr_cnt++;
          if (arr_q.size() == 0) chk("arr_unexpected", 1, 0);
          else begin
            ea = arr_q.pop_front();
            chk("arr_we", bus.arr_we_o, ea.we);
            chk("arr_idx", bus.arr_idx_o, ea.idx);
            chk("arr_way", bus.arr_way_o, ea.way);
            if (ea.we) begin
              chk("arr_wtag", bus.arr_wtag_o, ea.tag);
              chk("arr_wdata", bus.arr_wdata_o, ea.data);
              chk("arr_wdirty", bus.arr_wdirty_o, ea.dirty);
              last_way = bus.arr_way_o; last_wdata = bus.arr_wdata_o; last_wdirty = bus.arr_wdirty_o;
            end
          end
        end
        if (bus.mem_req_o) begin
          req_run++;
          if (hold) begin
            chk("mem_we_stable", bus.mem_we_o, held.we);
            chk("mem_addr_stable", bus.mem_addr_o, held.addr);
            chk("mem_be_stable", bus.mem_be_o, held.be);
            chk("mem_wdata_stable", bus.mem_wdata_o, held.data);
          end
          if (bus.mem_gnt_i) begin
            hold = 0;
            last_req_run = req_run;
            req_run = 0;
            if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
            else begin
              em = mem_q.pop_front();
              chk("mem_we", bus.mem_we_o, em.we);
              chk("mem_addr", bus.mem_addr_o, em.addr);
              chk("mem_be", bus.mem_be_o, em.be);
              if (em.we) chk("mem_wdata", bus.mem_wdata_o, em.data);
            end
            if (bus.mem_we_o) begin
              mem_wr_cnt++; last_mem_be = bus.mem_be_o; last_mem_wdata = bus.mem_wdata_o;
            end else last_rd_addr = bus.mem_addr_o;
          end else begin
            hold = 1;
            held = '{we: bus.mem_we_o, addr: bus.mem_addr_o, be: bus.mem_be_o, data: bus.mem_wdata_o};
          end
        end else begin
          hold = 0; req_run = 0;
        end
        if (bus.done_o) begin
          done_cnt++;
          busy = 0;
          last_done = bus.rdata_o;
          if (done_q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            ed = done_q.pop_front();
            if (ed.chk) chk("done_rdata", bus.rdata_o, ed.data);
          end
        end
        if (bus.miss_valid_i && bus.miss_ready_o) begin
          busy = 1; busy_addr = bus.miss_addr_i;
        end
      end
    end
  end

  task automatic issue(input logic [33:0] a, input logic we, input logic [31:0] wd,
                       input logic [3:0] be, input logic byp);
    bit ok;
    ok = 0;
    expect_txn(a, we, wd, be, byp);
    bus.miss_addr_i = a; bus.miss_we_i = we; bus.miss_wdata_i = wd;
    bus.miss_be_i = be; bus.miss_bypass_i = byp; bus.miss_valid_i = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.miss_ready_o;
      @(posedge clk); #1;
    end
    bus.miss_valid_i = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input string name);
    int start;
    bit ok;
    start = done_cnt; ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (done_cnt > start);
    end
    chk(name, ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int wr0, arr0, dn0;
    bit seen;
    rst = 1'b1;
    bus.miss_valid_i = 0; bus.miss_addr_i = '0; bus.miss_we_i = 0;
    bus.miss_wdata_i = '0; bus.miss_be_i = '0; bus.miss_bypass_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arr_req", bus.arr_req_o, 0);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_mshr_valid", bus.mshr_valid_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Partially valid set: lowest invalid way, no writeback, line-aligned refill.
    arr_valid_v = 8'b0000_0111; arr_dirty_v = 8'h00; refill_line = 64'h0123_4567_89AB_CDEF;
    wr0 = mem_wr_cnt;
    issue({27'h123_4567, 4'h5, 3'b100}, 0, 32'h0, 4'h0, 0);
    wait_done("t1_done");
    chk("t1_way", last_way, 8'b0000_1000);
    chk("t1_wdirty", last_wdirty, 0);
    chk("t1_refill_addr", last_rd_addr, {27'h123_4567, 4'h5, 3'b000});
    chk("t1_no_wb", mem_wr_cnt - wr0, 0);

    // Full set, only way 0 dirty: nine misses walk the round-robin pointer through a wrap.
    arr_valid_v = 8'hFF; arr_dirty_v = 8'h01;
    wr0 = mem_wr_cnt;
    for (int i = 0; i < 9; i++) begin
      vict_tag_v = 27'h0AB_C000 + 27'(i);
      vict_data_v = {32'hFEED_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
      refill_line = {32'h7000_0000 + 32'(i), 32'h0000_7000};
      issue({27'h200_0000 + 27'(i), 4'(i), 3'b000}, 0, 32'h0, 4'h0, 0);
      wait_done("t2_done");
      if (i == 0) chk("t2_wb_be", last_mem_be, 8'hFF);
    end
    chk("t2_wrap_way", last_way, 8'h01);
    chk("t2_wb_count", mem_wr_cnt - wr0, 2);

    // Store miss into upper word, two low bytes replaced.
    arr_dirty_v = 8'h00; refill_line = 64'h1111_2222_3333_4444;
    issue({27'h000_0003, 4'h2, 3'b100}, 1, 32'hAAAA_BBBB, 4'b0011, 0);
    wait_done("t3_done");
    chk("t3_way", last_way, 8'h02);
    chk("t3_wdata", last_wdata, 64'h1111_BBBB_3333_4444);
    chk("t3_wdirty", last_wdirty, 1);

    // Uncached store and load never touch the arrays.
    arr0 = arr_cnt;
    issue({27'h1FF_0000, 4'h9, 3'b100}, 1, 32'h1234_5678, 4'hF, 1);
    wait_done("t4_done");
    chk("t4_be", last_mem_be, 8'hF0);
    chk("t4_wdata", last_mem_wdata, 64'h1234_5678_1234_5678);
    refill_line = 64'hDEAD_BEEF_CAFE_F00D;
    issue({27'h1FF_0001, 4'hA, 3'b000}, 0, 32'h0, 4'h0, 1);
    wait_done("t4b_done");
    chk("t4b_rdata", last_done, 64'hDEAD_BEEF_CAFE_F00D);
    chk("t4_no_arr", arr_cnt - arr0, 0);

    // Refill grant withheld five cycles while a second request waits.
    gnt_delay = 5; refill_line = 64'h0F0F_0F0F_F0F0_F0F0;
    issue({27'h055_5555, 4'h3, 3'b000}, 0, 32'h0, 4'h0, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = bus.mem_req_o; end
    chk("t5_req_seen", seen, 1);
    @(posedge clk); #1;
    bus.miss_addr_i = {27'h011_1111, 4'h1, 3'b000}; bus.miss_bypass_i = 0; bus.miss_valid_i = 1;
    repeat (3) begin @(posedge clk); #1; end
    bus.miss_valid_i = 0;
    wait_done("t5_done");
    chk("t5_req_cycles", last_req_run, 6);
    gnt_delay = 0;

    // Reset while waiting for refill data; the late data must be ignored.
    rv_delay = 3; arr_dirty_v = 8'h00;
    issue({27'h066_6666, 4'h4, 3'b000}, 0, 32'h0, 4'h0, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); seen = bus.mem_req_o && bus.mem_gnt_i;
    end
    chk("t6_refill_gnt", seen, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; rr_model = 0;
    dn0 = done_cnt;
    @(negedge clk);
    chk("t6_arr_req", bus.arr_req_o, 0);
    chk("t6_mem_req", bus.mem_req_o, 0);
    chk("t6_mshr_valid", bus.mshr_valid_o, 0);
    chk("t6_ready", bus.miss_ready_o, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_done", done_cnt - dn0, 0);
    rv_delay = 0;

    // Pointer restarted at way 0, which is dirty.
    arr_dirty_v = 8'h01; vict_tag_v = 27'h777_7777; vict_data_v = 64'hABCD_0000_0000_DCBA;
    wr0 = mem_wr_cnt;
    issue({27'h099_9999, 4'h7, 3'b000}, 0, 32'h0, 4'h0, 0);
    wait_done("t7_done");
    chk("t7_way", last_way, 8'h01);
    chk("t7_wb", mem_wr_cnt - wr0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("arr_q_empty", arr_q.size(), 0);
    chk("mem_q_empty", mem_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
